uc_tx: RTL and testbench
========================

UC_TX -- requirements
Module: uc_tx

Interface
REQ-001 SHALL have parameter TICK_DIV, default 69445, meaning clk cycles per line tick (40 MHz / 69445).
REQ-002 SHALL have parameter PRE_TICKS, default 16, meaning preamble length in ticks.
REQ-003 SHALL have parameter SYM_TICKS, default 16, meaning ticks per line symbol.
REQ-004 SHALL have parameter GAP_TICKS, default 32, meaning post-frame low guard in ticks.
REQ-005 SHALL have port clk  input  1  system clock, 40 MHz; the single clock for all logic.
REQ-006 SHALL have port rst  input  1  reset; synchronous to clk, active-high.
REQ-007 SHALL have port code  input  5  command code; 0-20 = 30.0-40.0 kHz in 0.5 kHz steps, 21 RUN, 22 STOP, 23 SWEEP, 24 LOCK.
REQ-008 SHALL have port send  input  1  request strobe; sampled every clk.
REQ-009 SHALL have port tx  output  1  serial line to the receiving CPLD.
REQ-010 SHALL have port busy  output  1  frame in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-012 SHALL have port err  output  1  one-cycle pulse on a rejected code.

Function
REQ-013 SHALL accept a request when send=1, busy=0, rst=0 (accept cycle A); code latched at A; send while busy=1 ignored, no queueing.
REQ-014 SHALL reject an accepted code >24: err=1 at A+1 for one cycle; no frame; tx stays 0; busy stays 0.
REQ-015 SHALL map a valid code v to a 6-bit payload P = v for v<=12 and P = v+1 for 13<=v<=24 (payload 13 is never sent).
REQ-016 SHALL Manchester-encode P MSB first, bit 0 -> symbols "0,1", bit 1 -> symbols "1,0", giving 12 symbols S[11:0], S[11] first.
REQ-017 SHALL use FSM states IDLE, PRE, DATA, GAP, with IDLE->PRE on a valid accept, PRE->DATA after PRE_TICKS ticks, DATA->GAP after 12 symbols, and GAP->IDLE after GAP_TICKS ticks.
REQ-018 SHALL restart the tick divider (0..TICK_DIV-1) at A, so that every state boundary falls at A+1+k*TICK_DIV.
REQ-019 SHALL drive tx = 1 in PRE, tx = the current symbol in DATA, each symbol held exactly SYM_TICKS*TICK_DIV cycles, and tx = 0 in IDLE and GAP.
REQ-020 SHALL make tx=1 from A+1 and make symbol S[11] start at A+1+PRE_TICKS*TICK_DIV.
REQ-021 SHALL assert busy from A+1 through the last GAP cycle and deassert it in the cycle after that.
REQ-022 SHALL pulse done for one cycle in the cycle busy falls, at A+1+(PRE_TICKS+12*SYM_TICKS+GAP_TICKS)*TICK_DIV (240 ticks at defaults).
REQ-023 SHALL accept a new send in the cycle done=1, so back-to-back frames are always separated by the GAP low.
REQ-024 SHALL leave an in-flight frame unaffected when code changes after A.

Reset
REQ-025 SHALL, with rst=1, set at the next clk edge: state IDLE, tx=0, busy=0, done=0, err=0, divider and counters 0.
REQ-026 SHALL abort a frame in progress when rst is asserted; tx=0 the following cycle; no done pulse for the aborted frame.
REQ-027 SHALL ignore send while rst=1.

Verification (TICK_DIV=4 for sim; symbols sampled at the middle of each symbol)
REQ-028 SHALL cover: code=2, send pulse -> tx high 64 cycles from A+1, then symbols 010101011001 of 64 cycles each, then 128 cycles low, done at A+961.
REQ-029 SHALL cover: code=13 -> symbols 010110101001; code=24 -> symbols 011010010110; code=12 -> symbols 010110100101.
REQ-030 SHALL cover: code=25, send -> err=1 at A+1 only; tx=0, busy=0 throughout.
REQ-031 SHALL cover: send re-pulsed mid-DATA with code=0 -> ignored, first frame symbols unchanged, exactly one done.
REQ-032 SHALL cover: rst asserted during symbol 5 -> tx=0 and busy=0 next cycle, no done; a new send after release gives a full correct frame.
REQ-033 SHALL cover: send held high continuously with code=21 -> repeated frames of symbols 011001101001, each preceded by >=128 low cycles.

Source files
------------

// File: rtl/uc_tx.sv
// uc_tx: serial command transmitter for the receiving CPLD.
// Each frame is a high preamble, then 12 Manchester symbols carrying a
// 6-bit payload, then a low guard gap. All timing is in line ticks of
// TICK_DIV clk cycles, and the tick divider restarts on every accepted request.
module uc_tx #(
  parameter int unsigned TICK_DIV  = 69445,
  parameter int unsigned PRE_TICKS = 16,
  parameter int unsigned SYM_TICKS = 16,
  parameter int unsigned GAP_TICKS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] code,
  input  logic       send,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MAX_T0  = (PRE_TICKS > SYM_TICKS) ? PRE_TICKS : SYM_TICKS;
  localparam int unsigned MAX_T   = (MAX_T0 > GAP_TICKS) ? MAX_T0 : GAP_TICKS;
  localparam int unsigned TCNT_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int unsigned NSYM    = 12;
  localparam int unsigned SCNT_W  = 4;
  localparam logic [4:0]  CODE_MAX   = 5'd24;
  localparam logic [4:0]  CODE_SKIP  = 5'd12;

  typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;

  state_t              state_q;
  logic [DIV_W-1:0]    div_q;
  logic [TCNT_W-1:0]   tcnt_q;
  logic [SCNT_W-1:0]   scnt_q;
  logic [NSYM-1:0]     sreg_q;

  logic [5:0]          payload_d;
  logic [NSYM-1:0]     sym_d;
  logic                tick_end;

  // Map the code to its payload (13 is skipped) and Manchester-encode it MSB first
  always_comb begin
    payload_d = 6'd0;
    sym_d     = '0;
    if (code <= CODE_SKIP) payload_d = {1'b0, code};
    else                   payload_d = {1'b0, code} + 6'd1;
    for (int i = 0; i < 6; i++) begin
      sym_d[2*i+1] = payload_d[i];
      sym_d[2*i]   = ~payload_d[i];
    end
  end

  assign tick_end = (div_q == DIV_W'(TICK_DIV - 1));

  // Frame sequencer: tick divider, per-state tick counter, symbol shifter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      tcnt_q  <= '0;
      scnt_q  <= '0;
      sreg_q  <= '0;
      tx      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state_q != IDLE) begin
        if (tick_end) div_q <= '0;
        else          div_q <= div_q + DIV_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (send) begin
            if (code > CODE_MAX) begin
              err <= 1'b1;
            end else begin
              state_q <= PRE;
              div_q   <= '0;
              tcnt_q  <= '0;
              scnt_q  <= '0;
              sreg_q  <= sym_d;
              tx      <= 1'b1;
              busy    <= 1'b1;
            end
          end
        end
        PRE: begin
          if (tick_end) begin
            if (tcnt_q == TCNT_W'(PRE_TICKS - 1)) begin
              tcnt_q  <= '0;
              state_q <= DATA;
              tx      <= sreg_q[NSYM-1];
            end else begin
              tcnt_q <= tcnt_q + TCNT_W'(1);
            end
          end
        end
        DATA: begin
          if (tick_end) begin
            if (tcnt_q == TCNT_W'(SYM_TICKS - 1)) begin
              tcnt_q <= '0;
              if (scnt_q == SCNT_W'(NSYM - 1)) begin
                state_q <= GAP;
                tx      <= 1'b0;
              end else begin
                scnt_q <= scnt_q + SCNT_W'(1);
                sreg_q <= {sreg_q[NSYM-2:0], 1'b0};
                tx     <= sreg_q[NSYM-2];
              end
            end else begin
              tcnt_q <= tcnt_q + TCNT_W'(1);
            end
          end
        end
        GAP: begin
          if (tick_end) begin
            if (tcnt_q == TCNT_W'(GAP_TICKS - 1)) begin
              tcnt_q  <= '0;
              state_q <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              tcnt_q <= tcnt_q + TCNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx      <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uc_tx.sv
// tb_uc_tx: directed and randomized frames for uc_tx at TICK_DIV=4,
// checked against a cycle-offset model of the frame timeline.
module tb_uc_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       send;
  logic [4:0] code;
  logic       tx, busy, done, err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uc_tx #(.TICK_DIV(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .code (code),
    .send (send),
    .tx   (tx),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected symbol stream from the code rules: payload skips 13, bit b -> (b, ~b)
  function automatic logic [11:0] model_syms(input int v);
    int p;
    int b;
    logic [11:0] s;
    p = (v <= 12) ? v : v + 1;
    s = '0;
    for (int k = 0; k < 12; k++) begin
      b = (p >> (5 - k / 2)) & 1;
      s[11 - k] = 1'((b ^ (k % 2)) & 1);
    end
    return s;
  endfunction

  // One frame: offset o counts cycles after the accept cycle A (o=1 is A+1)
  task automatic frame(input logic [4:0] c, input logic [11:0] exp_s,
                       input bit hold, input bit mid_send);
    logic exp_tx;
    code = c;
    send = 1'b1;
    step();
    if (!hold) send = 1'b0;
    code = 5'($urandom_range(0, 31));
    for (int o = 1; o <= 961; o++) begin
      if (o <= 64)       exp_tx = 1'b1;
      else if (o <= 832) exp_tx = exp_s[11 - (o - 65) / 64];
      else               exp_tx = 1'b0;
      if (o == 1 || o == 64 || o == 65 || o == 832) chk("tx_edge", tx, exp_tx);
      if (o >= 65 && o <= 832 && ((o - 65) % 64) == 32) chk("tx_sym", tx, exp_tx);
      if (o >= 833) chk("tx_gap", tx, exp_tx);
      chk("busy", busy, (o <= 960) ? 1'b1 : 1'b0);
      chk("done", done, (o == 961) ? 1'b1 : 1'b0);
      if (o == 1) chk("err_frame", err, 1'b0);
      if (mid_send && o == 300) begin
        send = 1'b1;
        code = 5'd0;
      end
      if (mid_send && o == 301) send = 1'b0;
      if (o < 961) step();
    end
  endtask

  task automatic bad_code(input logic [4:0] c);
    code = c;
    send = 1'b1;
    step();
    send = 1'b0;
    chk("err_pulse", err, 1'b1);
    chk("err_busy", busy, 1'b0);
    chk("err_tx", tx, 1'b0);
    for (int i = 0; i < 30; i++) begin
      step();
      chk("err_after", err, 1'b0);
      chk("err_busy_after", busy, 1'b0);
      chk("err_tx_after", tx, 1'b0);
    end
  endtask

  initial begin
    int v;
    rst  = 1'b1;
    send = 1'b0;
    code = 5'd0;
    step();
    step();
    chk("rst_tx", tx, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    step();

    // Directed frames with literal symbol patterns
    frame(5'd2,  12'b010101011001, 1'b0, 1'b0);
    frame(5'd13, 12'b010110101001, 1'b0, 1'b0);
    frame(5'd24, 12'b011010010110, 1'b0, 1'b0);
    frame(5'd12, 12'b010110100101, 1'b0, 1'b0);

    // Rejected codes
    bad_code(5'd25);
    bad_code(5'd31);

    // Re-pulsed send during DATA is ignored
    frame(5'd7, model_syms(7), 1'b0, 1'b1);

    // Random valid codes
    repeat (3) begin
      v = int'($urandom_range(0, 24));
      frame(5'(v), model_syms(v), 1'b0, 1'b0);
    end

    // Reset during symbol 5 aborts the frame; send during reset is ignored
    v = int'($urandom_range(0, 24));
    code = 5'(v);
    send = 1'b1;
    step();
    send = 1'b0;
    for (int o = 1; o < 417; o++) step();
    chk("abort_pre_busy", busy, 1'b1);
    rst  = 1'b1;
    send = 1'b1;
    step();
    chk("abort_tx", tx, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_err", err, 1'b0);
    rst  = 1'b0;
    send = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (done !== 1'b0 || tx !== 1'b0 || busy !== 1'b0 || i == 999) begin
        chk("abort_quiet_done", done, 1'b0);
        chk("abort_quiet_tx", tx, 1'b0);
        chk("abort_quiet_busy", busy, 1'b0);
      end
    end
    frame(5'(v), model_syms(v), 1'b0, 1'b0);

    // Send held high: frames repeat, each starting in the previous done cycle
    for (int f = 0; f < 3; f++) frame(5'd21, 12'b011001101001, 1'b1, 1'b0);
    send = 1'b0;
    step();
    chk("hold_end_busy", busy, 1'b0);
    chk("hold_end_tx", tx, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
